// File: rtl/wb_gpio_arbiter.sv
// Two-master round-robin Wishbone arbiter and sequencer for the 8-bit GPIO slave (adr 0 data, adr 1 dir).
// Define WB_GPIO_ARB_TIMEOUT_EN to end a stalled transfer with an error after TIMEOUT_CYCLES cycles.
module wb_gpio_arbiter #(
  parameter logic RESET_PRIO     = 1'b0,
  parameter int   TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [1:0]  m_adr_i,
  input  logic [15:0] m_dat_i,
  output logic [7:0]  m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [1:0]  o_grant,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_adr_o,
  output logic [7:0]  s_dat_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [7:0]  s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  typedef enum logic [1:0] {IDLE, XFER, CAPT, RESP} state_t;

  state_t     state, state_nx;
  logic       prio, prio_nx;
  logic [1:0] grant_nx, ack_nx, err_nx;
  logic       cyc_nx, we_nx, adr_nx;
  logic [7:0] sdat_nx, mdat_nx;
  logic [1:0] req;
  logic       pick, cur, owner_cyc, timeout;

  assign s_cti_o   = 3'b000;
  assign s_bte_o   = 2'b00;
  assign s_stb_o   = s_cyc_o;
  assign req       = m_cyc_i & m_stb_i;
  assign cur       = o_grant[1];
  assign owner_cyc = |(o_grant & m_cyc_i);

`ifdef WB_GPIO_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;

  // Counts completed XFER cycles; zero on the first XFER cycle of every transfer.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || state != XFER) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign timeout = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    grant_nx = o_grant;
    ack_nx   = 2'b00;
    err_nx   = 2'b00;
    cyc_nx   = s_cyc_o;
    we_nx    = s_we_o;
    adr_nx   = s_adr_o;
    sdat_nx  = s_dat_o;
    mdat_nx  = m_dat_o;
    pick     = (req == 2'b11) ? prio : req[1];
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = pick ? 2'b10 : 2'b01;
          we_nx    = m_we_i[pick];
          adr_nx   = m_adr_i[pick];
          sdat_nx  = pick ? m_dat_i[15:8] : m_dat_i[7:0];
          cyc_nx   = 1'b1;
          state_nx = XFER;
        end
      end
      XFER: begin
        // A granted master abandoning its cycle wins over any slave response.
        if (!owner_cyc) begin
          cyc_nx   = 1'b0;
          grant_nx = 2'b00;
          prio_nx  = ~cur;
          state_nx = IDLE;
        end else if (s_err_i) begin
          cyc_nx   = 1'b0;
          err_nx   = o_grant;
          state_nx = RESP;
        end else if (s_ack_i) begin
          cyc_nx = 1'b0;
          if (s_we_o) begin
            ack_nx   = o_grant;
            state_nx = RESP;
          end else begin
            state_nx = CAPT;
          end
        end else if (timeout) begin
          cyc_nx   = 1'b0;
          err_nx   = o_grant;
          state_nx = RESP;
        end
      end
      CAPT: begin
        if (!owner_cyc) begin
          grant_nx = 2'b00;
          prio_nx  = ~cur;
          state_nx = IDLE;
        end else begin
          mdat_nx  = s_dat_i;
          ack_nx   = o_grant;
          state_nx = RESP;
        end
      end
      RESP: begin
        grant_nx = 2'b00;
        prio_nx  = ~cur;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      prio    <= RESET_PRIO;
      o_grant <= 2'b00;
      m_ack_o <= 2'b00;
      m_err_o <= 2'b00;
      m_dat_o <= 8'h00;
      s_cyc_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= 1'b0;
      s_dat_o <= 8'h00;
    end else begin
      state   <= state_nx;
      prio    <= prio_nx;
      o_grant <= grant_nx;
      m_ack_o <= ack_nx;
      m_err_o <= err_nx;
      m_dat_o <= mdat_nx;
      s_cyc_o <= cyc_nx;
      s_we_o  <= we_nx;
      s_adr_o <= adr_nx;
      s_dat_o <= sdat_nx;
    end
  end

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Directed testbench for wb_gpio_arbiter with a zero-wait GPIO slave stub and a response scoreboard.
// Also covers the WB_GPIO_ARB_TIMEOUT_EN build when that macro is defined for both files.
module tb_wb_gpio_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i, m_adr_i;
  logic [15:0] m_dat_i;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, o_grant;
  logic        s_cyc_o, s_stb_o, s_we_o, s_adr_o;
  logic [7:0]  s_dat_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [7:0]  s_dat_i;
  logic        s_ack_i, s_err_i;

  logic        stub_ack_en, stub_err_en;
  logic [7:0]  gpio_in, data_reg, dir_reg;

  typedef struct {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] data;
    bit         chk_data;
    int         lat;
  } resp_t;

  resp_t sb_q[$];
  int    assert_count = 0;
  int    fail_count   = 0;
  int    stb_seen;
  int    resp_seen;

  wb_gpio_arbiter #(.RESET_PRIO(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .o_grant(o_grant), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 i_clk = ~i_clk;

  // Zero-wait GPIO slave: combinational ack, registered read data one cycle after the address.
  assign s_ack_i = s_cyc_o & s_stb_o & stub_ack_en;
  assign s_err_i = s_cyc_o & s_stb_o & stub_err_en;

  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      data_reg <= 8'h00;
      dir_reg  <= 8'h00;
      s_dat_i  <= 8'h00;
    end else begin
      if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
        if (s_adr_o) dir_reg  <= s_dat_o;
        else         data_reg <= s_dat_o;
      end
      s_dat_i <= s_adr_o ? dir_reg : gpio_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int master, input logic req, input logic we,
                               input logic adr, input logic [7:0] dat);
    m_cyc_i[master]       = req;
    m_stb_i[master]       = req;
    m_we_i[master]        = we;
    m_adr_i[master]       = adr;
    m_dat_i[8*master +: 8] = dat;
  endtask

  task automatic pushExpect(input logic [1:0] ack, input logic [1:0] err,
                            input logic [7:0] data, input bit chk_data, input int lat);
    resp_t r;
    r.ack = ack; r.err = err; r.data = data; r.chk_data = chk_data; r.lat = lat;
    sb_q.push_back(r);
  endtask

  // Steps negedges until an ack/err pulse appears, then pops the scoreboard and compares.
  task automatic waitResponse(input string tag, input int budget, input int offset, output int stb_cnt);
    resp_t exp;
    bit    got = 0;
    stb_cnt = 0;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge i_clk);
      if (s_stb_o) stb_cnt++;
      if ((m_ack_o | m_err_o) != 2'b00) begin
        got = 1;
        if (sb_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $error("[TB] FAIL %s: unexpected response ack=%b err=%b", tag, m_ack_o, m_err_o);
        end else begin
          exp = sb_q.pop_front();
          checkOutput({tag, "_ack"}, 32'(m_ack_o), 32'(exp.ack));
          checkOutput({tag, "_err"}, 32'(m_err_o), 32'(exp.err));
          if (exp.chk_data) checkOutput({tag, "_data"}, 32'(m_dat_o), 32'(exp.data));
          if (exp.lat > 0)  checkOutput({tag, "_lat"}, 32'(i + offset), 32'(exp.lat));
        end
      end
    end
    if (!got) begin
      assert_count++;
      fail_count++;
      $error("[TB] FAIL %s: no response within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    i_reset_n   = 1'b0;
    m_cyc_i     = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00; m_adr_i = 2'b00;
    m_dat_i     = 16'h0000;
    stub_ack_en = 1'b1;
    stub_err_en = 1'b0;
    gpio_in     = 8'h00;
    repeat (3) @(negedge i_clk);
    $display("[TB] reset state");
    checkOutput("rst_grant", 32'(o_grant), 32'h0);
    checkOutput("rst_ack", 32'({m_ack_o, m_err_o}), 32'h0);
    checkOutput("rst_slave", 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}), 32'h0);
    checkOutput("rst_mdat", 32'(m_dat_o), 32'h0);
    checkOutput("rst_cti_bte", 32'({s_cti_o, s_bte_o}), 32'h0);
    i_reset_n = 1'b1;

    $display("[TB] m0 writes dir=FF");
    @(negedge i_clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'hFF);
    pushExpect(2'b01, 2'b00, 8'h00, 1'b0, 2);
    @(negedge i_clk);
    checkOutput("wr1_stb", 32'({s_cyc_o, s_stb_o, s_we_o, s_adr_o}), 32'hF);
    checkOutput("wr1_sdat", 32'(s_dat_o), 32'hFF);
    checkOutput("wr1_grant", 32'(o_grant), 32'h1);
    waitResponse("wr1", 8, 1, stb_seen);
    checkOutput("wr1_stb_cycles", 32'(stb_seen), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("wr1_grant_idle", 32'(o_grant), 32'h0);
    checkOutput("wr1_ack_pulse", 32'(m_ack_o), 32'h0);
    checkOutput("wr1_dir_reg", 32'(dir_reg), 32'hFF);

    $display("[TB] m1 reads gpio inputs");
    gpio_in = 8'hA5;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h00);
    pushExpect(2'b10, 2'b00, 8'hA5, 1'b1, 3);
    waitResponse("rd1", 8, 0, stb_seen);
    checkOutput("rd1_stb_cycles", 32'(stb_seen), 32'h1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("rd1_grant_idle", 32'(o_grant), 32'h0);
    checkOutput("rd1_hold", 32'(m_dat_o), 32'hA5);

    $display("[TB] write keeps read data, then read dir");
    gpio_in = 8'h00;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h3C);
    pushExpect(2'b01, 2'b00, 8'hA5, 1'b1, 2);
    waitResponse("wr2", 8, 0, stb_seen);
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h00);
    pushExpect(2'b01, 2'b00, 8'hFF, 1'b1, 4);
    waitResponse("rd2", 8, 0, stb_seen);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("wr2_data_reg", 32'(data_reg), 32'h3C);

    $display("[TB] slave error");
    stub_ack_en = 1'b0;
    stub_err_en = 1'b1;
    @(negedge i_clk);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'h99);
    pushExpect(2'b00, 2'b10, 8'h00, 1'b0, 2);
    waitResponse("serr", 8, 0, stb_seen);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    stub_ack_en = 1'b1;
    stub_err_en = 1'b0;

    $display("[TB] round robin from reset");
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h11);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'h22);
    for (int k = 0; k < 4; k++) begin
      pushExpect((k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 8'h00, 1'b0, (k == 0) ? 2 : 3);
      waitResponse("rr", 8, 0, stb_seen);
      checkOutput("rr_stb_cycles", 32'(stb_seen), 32'h1);
      checkOutput("rr_data_reg", 32'(data_reg), (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);

    $display("[TB] m0 aborts read in CAPT");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("abt_grant_m0", 32'(o_grant), 32'h1);
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 8'h77);
    @(negedge i_clk);
    checkOutput("abt_capt_slave", 32'({s_cyc_o, s_stb_o}), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("abt_no_resp", 32'({m_ack_o, m_err_o}), 32'h0);
    checkOutput("abt_grant_idle", 32'(o_grant), 32'h0);
    @(negedge i_clk);
    checkOutput("abt_grant_m1", 32'(o_grant), 32'h2);
    pushExpect(2'b10, 2'b00, 8'h00, 1'b0, 0);
    waitResponse("abt_m1", 8, 0, stb_seen);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("abt_dir_reg", 32'(dir_reg), 32'h77);

    $display("[TB] silent slave");
    stub_ack_en = 1'b0;
    @(negedge i_clk);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h5A);
`ifdef WB_GPIO_ARB_TIMEOUT_EN
    pushExpect(2'b00, 2'b01, 8'h00, 1'b0, 17);
    waitResponse("tmo", 30, 0, stb_seen);
    checkOutput("tmo_stb_cycles", 32'(stb_seen), 32'd16);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
`else
    stb_seen  = 0;
    resp_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (s_stb_o) stb_seen++;
      if ((m_ack_o | m_err_o) != 2'b00) resp_seen++;
    end
    checkOutput("stall_stb_cycles", 32'(stb_seen), 32'd40);
    checkOutput("stall_no_resp", 32'(resp_seen), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("stall_release", 32'({s_cyc_o, o_grant}), 32'h0);
`endif
    stub_ack_en = 1'b1;

    $display("[TB] reset during XFER");
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'hC3);
    @(negedge i_clk);
    checkOutput("mrst_stb", 32'(s_stb_o), 32'h1);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    checkOutput("mrst_outputs", 32'({o_grant, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o}), 32'h0);
    checkOutput("mrst_sdat", 32'(s_dat_o), 32'h0);
    i_reset_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'h44);
    @(negedge i_clk);
    checkOutput("mrst_prio_grant", 32'(o_grant), 32'h1);
    pushExpect(2'b01, 2'b00, 8'h00, 1'b0, 0);
    waitResponse("mrst_m0", 8, 0, stb_seen);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    pushExpect(2'b10, 2'b00, 8'h00, 1'b0, 0);
    waitResponse("mrst_m1", 8, 0, stb_seen);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge i_clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
